// File: rtl/seq_div_nb_pkg.sv
// Shared definitions for the sequential restoring divider and its CLA subtractor.
package seq_div_nb_pkg;

   localparam int unsigned DIV_N       = 16;
   localparam int unsigned DIV_SLICE_W = 4;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Iteration counter width; counts N-1 down to 0.
   function automatic int unsigned div_cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cla_sub_nb.sv
// Combinational (N+1)-bit subtractor a - b built as a + ~b + 1 over a chain of
// 4-bit carry-lookahead slices plus one top bit; no_borrow is the final carry-out.
module cla_sub_nb
   import seq_div_nb_pkg::*;
#(
   parameter int unsigned N = DIV_N
) (
   input  logic [N:0] a,
   input  logic [N:0] b,
   output logic [N:0] diff,
   output logic       no_borrow
);

   localparam int unsigned NS = N / DIV_SLICE_W;

   logic [N:0]  b_inv;
   logic [NS:0] slice_c;

   assign b_inv      = ~b;
   assign slice_c[0] = 1'b1;

   for (genvar s = 0; s < NS; s++) begin : g_slice
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;

      assign g    = a[DIV_SLICE_W*s +: 4] & b_inv[DIV_SLICE_W*s +: 4];
      assign p    = a[DIV_SLICE_W*s +: 4] ^ b_inv[DIV_SLICE_W*s +: 4];
      assign c[0] = slice_c[s];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);
      assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

      assign diff[DIV_SLICE_W*s +: 4] = p ^ c[3:0];
      assign slice_c[s+1]             = c[4];
   end

   // Single top bit rippled from the last slice.
   assign diff[N]   = a[N] ^ b_inv[N] ^ slice_c[NS];
   assign no_borrow = (a[N] & b_inv[N]) | ((a[N] ^ b_inv[N]) & slice_c[NS]);

endmodule

// File: rtl/seq_div_nb.sv
// Sequential unsigned restoring divider: N iterations through one shared CLA
// subtractor, with a start/busy/done handshake and divide-by-zero flagging.
module seq_div_nb
   import seq_div_nb_pkg::*;
#(
   parameter int unsigned N = DIV_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);

   localparam int unsigned CW = div_cnt_w(N);

   div_state_e   state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [N-1:0] r_q, r_d;
   logic [N-1:0] q_q, q_d;
   logic [N-1:0] dvs_q, dvs_d;
   logic [N-1:0] quo_d, rem_d;
   logic         busy_d, done_d, dbz_d;

   logic [N:0]   sub_a, sub_b, diff;
   logic         no_borrow, q_bit;
   logic [N-1:0] r_step, q_step;

   // One restoring step: shift {R,Q} left, trial-subtract the divisor.
   assign sub_a  = {r_q, q_q[N-1]};
   assign sub_b  = {1'b0, dvs_q};
   // diff[N] is always 0 when there is no borrow; folding it in keeps the bit live.
   assign q_bit  = no_borrow & ~diff[N];
   assign r_step = q_bit ? diff[N-1:0] : sub_a[N-1:0];
   assign q_step = {q_q[N-2:0], q_bit};

   cla_sub_nb #(.N(N)) u_sub (
      .a         (sub_a),
      .b         (sub_b),
      .diff      (diff),
      .no_borrow (no_borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DIV_IDLE;
         count_q     <= '0;
         r_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         r_q         <= r_d;
         q_q         <= q_d;
         dvs_q       <= dvs_d;
         quotient    <= quo_d;
         remainder   <= rem_d;
         busy        <= busy_d;
         done        <= done_d;
         div_by_zero <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      r_d     = r_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      quo_d   = quotient;
      rem_d   = remainder;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      dbz_d   = div_by_zero;

      case (state_q)
         DIV_IDLE, DIV_DONE: begin
            state_d = DIV_IDLE;
            if (start) begin
               dvs_d = divisor;
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  state_d = DIV_DONE;
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = DIV_CALC;
                  count_d = CW'(N - 1);
                  r_d     = '0;
                  q_d     = dividend;
                  busy_d  = 1'b1;
               end
            end
         end
         DIV_CALC: begin
            r_d = r_step;
            q_d = q_step;
            if (count_q == '0) begin
               state_d = DIV_DONE;
               quo_d   = q_step;
               rem_d   = r_step;
               done_d  = 1'b1;
            end else begin
               count_d = count_q - CW'(1);
               busy_d  = 1'b1;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

endmodule
